instr_fetch_sequencer: RTL
==========================

Name: instr_fetch_sequencer

Overview:
Fetch-side controller for the combinational, word-indexed instruction memory.
- Owns the program counter and drives the memory address.
- Captures each returned instruction into a 2-entry fetch queue, with its PC.
- Presents queue entries to decode through a valid/ready handshake.
- Handles stall, branch/jump redirect with queue flush, and out-of-range detection.

Parameters:
- IM_DEPTH, 512, number of 32-bit words in instruction memory; the valid word index is 0..IM_DEPTH-1.
- QUEUE_DEPTH, 2, fetch queue entries; must be a power of 2 and at least 2.
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  while high, suppresses new fetches; the queue may still drain.
- Redirect  in  1  one-cycle pulse that loads a new PC and flushes the queue.
- RedirectPC  in  32  target PC; bits [1:0] are ignored and forced to 0.
- IM_Address  out  32  byte address to instruction memory; always the current PC.
- IM_Instruction  in  32  combinational read data for IM_Address.
- FetchValid  out  1  queue head is valid.
- FetchReady  in  1  decode accepts the head this cycle.
- FetchInstr  out  32  instruction at the queue head.
- FetchPC  out  32  PC of the head entry.
- FetchPCPlus4  out  32  FetchPC + 4.
- OutOfRange  out  1  sticky; the PC word index reached or exceeded IM_DEPTH.
- Halted  out  1  the sequencer is in the HALT state.

Behaviour:
Reset:
- PC = RESET_PC, queue empty, state = RUN.
- FetchValid = 0, FetchInstr = 0, FetchPC = 0, FetchPCPlus4 = 4, OutOfRange = 0, Halted = 0.

IM_Address and memory read:
- IM_Address = PC, driven combinationally from the PC register.
- The instruction is sampled in the same cycle it is addressed; read latency is 0.

States:
- RUN: normal fetching.
- HALT: absorbing state; exit only by Reset.
- Halted = (state == HALT).

Push (RUN only):
- Condition: !Stall && !Redirect && (count < QUEUE_DEPTH || pop) && PC[31:2] < IM_DEPTH.
- Action: enqueue {PC, IM_Instruction}, then PC <= PC + 4. 32-bit wrap is irrelevant because the range check fires first.

Pop:
- Condition: FetchValid && FetchReady.
- Simultaneous push and pop when full is allowed; count is unchanged.
- FetchInstr, FetchPC and FetchPCPlus4 are combinational from the head entry and are 0 when the queue is empty.

Redirect (highest priority after Reset):
- PC <= {RedirectPC[31:2], 2'b00}, queue count <= 0.
- No push and no pop that cycle, even if FetchReady is high.
- The first instruction from the target is visible the following cycle.
- Redirect overrides Stall.
- Redirect in HALT is ignored.

Range check:
- When PC[31:2] >= IM_DEPTH in RUN with no Redirect: nothing is pushed, OutOfRange <= 1, state <= HALT.
- Entries already queued continue to drain in HALT.

Stall:
- While Stall is high, PC holds and pops still occur.
- Fetch-to-FetchValid latency after a push is 1 cycle.

Queue pointers:
- Rd/wr pointers are log2(QUEUE_DEPTH) bits and wrap modulo QUEUE_DEPTH.
- count is log2(QUEUE_DEPTH)+1 bits.

Optional Feature:
Macro: FETCH_HALT_ON_BREAK_EN.
- Defined: when the pushed instruction equals the MIPS BREAK encoding (opcode 0, funct 6'h0D):
  - The entry is still enqueued.
  - The PC does not advance.
  - State <= HALT the same edge.
  - OutOfRange stays 0.
- Undefined: BREAK is fetched like any other instruction.

Decomposition:
Package fetch_pkg:
- Entry typedef {pc[31:0], instr[31:0]}.
- Constants: FUNCT_BREAK = 6'h0D, OPCODE_SPECIAL = 6'h00.
- State enum {RUN, HALT}.

Sub-module fetch_queue:
- Parameterised synchronous FIFO with push, pop, flush, count, head outputs.
- The sequencer instantiates it.

Test Plan:
1. Reset, then FetchReady = 1, Stall = 0, memory[i] = i*4.
   - Required: FetchPC sequence 0, 4, 8, ... with FetchInstr == FetchPC.
   - Required: FetchValid first high 1 cycle after Reset drops.
2. FetchReady = 0 for 5 cycles.
   - Required: exactly 2 pushes, PC = 8.
   - Required: IM_Address held at 8 with no further pushes.
   - Required: on release, heads 0, 4, 8 pop in order with no loss or duplication.
3. Redirect with RedirectPC = 32'h0000_0043 while the queue holds 2 entries.
   - Required: next cycle FetchValid = 0, IM_Address = 32'h40.
   - Required: the following cycle FetchPC = 32'h40.
4. Stall = 1 for 3 cycles with a full queue and FetchReady = 1.
   - Required: both entries drain, PC is unchanged, FetchValid = 0 after the drain.
   - Required: Stall together with Redirect still loads the target.
5. IM_DEPTH = 8, free-run.
   - Required: last push has PC = 28; at PC = 32, OutOfRange = 1 and Halted = 1.
   - Required: queued entries still pop; a later Redirect is ignored; Reset clears all.
6. (FETCH_HALT_ON_BREAK_EN) memory[3] = 32'h0000_000D.
   - Required: entry at PC = 12 is delivered, Halted = 1, PC stays 12, OutOfRange = 0.
   - Required: without the macro, fetch continues to PC = 16.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the fetch queue entry layout, the MIPS BREAK encoding and the sequencer states.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    localparam logic [5:0] OPCODE_SPECIAL = 6'h00;
    localparam logic [5:0] FUNCT_BREAK    = 6'h0D;

    // BREAK is identified by opcode and funct only; the code field in between is ignored.
    localparam logic [31:0] BREAK_MASK  = 32'hFC00_003F;
    localparam logic [31:0] BREAK_MATCH = {OPCODE_SPECIAL, 20'h0_0000, FUNCT_BREAK};

    function automatic logic is_break(input logic [31:0] instr);
        return (instr & BREAK_MASK) == BREAK_MATCH;
    endfunction

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// Bundle of the fetch sequencer's control, instruction memory and decode handshake signals.
// The master modport is the sequencer side; slave is the memory/decode environment side.
interface instr_fetch_sequencer_if;

    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] im_address;
    logic [31:0] im_instruction;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_plus4;
    logic        out_of_range;
    logic        halted;

    modport master (
        input  stall,
        input  redirect,
        input  redirect_pc,
        input  im_instruction,
        input  fetch_ready,
        output im_address,
        output fetch_valid,
        output fetch_instr,
        output fetch_pc,
        output fetch_pc_plus4,
        output out_of_range,
        output halted
    );

    modport slave (
        output stall,
        output redirect,
        output redirect_pc,
        output im_instruction,
        output fetch_ready,
        input  im_address,
        input  fetch_valid,
        input  fetch_instr,
        input  fetch_pc,
        input  fetch_pc_plus4,
        input  out_of_range,
        input  halted
    );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} entries between fetch and decode.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output entry_t           head
);

    entry_t             slots [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    // A push into a full queue is only legal when the head leaves the same cycle.
    assign do_pop  = pop && !flush && (count != '0);
    assign do_push = push && !flush && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Fetch-side controller: owns the PC, fills a fetch queue from combinational instruction memory,
// and handles stall, redirect/flush and out-of-range halt. FETCH_HALT_ON_BREAK_EN adds halt on BREAK.
module instr_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned IM_DEPTH    = 512,
    parameter int unsigned QUEUE_DEPTH = 2,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input logic                     clk,
    input logic                     reset,
    instr_fetch_sequencer_if.master bus
);

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t       state_q;
    fetch_state_t       state_d;
    logic [31:0]        pc_q;
    logic [31:0]        pc_d;
    logic               oor_q;
    logic               oor_d;
    logic               push;
    logic               pop;
    logic               flush;
    logic               redirect_take;
    logic               in_range;
    logic               q_empty;
    logic               q_full;
    logic [CNT_W-1:0]   q_count;
    entry_t             head;
    entry_t             push_data;

    assign q_empty       = (q_count == '0);
    assign q_full        = (q_count == CNT_W'(QUEUE_DEPTH));
    assign in_range      = (pc_q[31:2] < 30'(IM_DEPTH));
    assign redirect_take = bus.redirect && (state_q == RUN);
    assign pop           = !q_empty && bus.fetch_ready && !redirect_take;
    assign push_data     = '{pc: pc_q, instr: bus.im_instruction};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            oor_q   <= oor_d;
        end
    end

    // Redirect beats the range check, which beats an ordinary fetch; HALT only drains.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        oor_d   = oor_q;
        push    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            RUN: begin
                if (redirect_take) begin
                    pc_d  = bus.redirect_pc & 32'hFFFF_FFFC;
                    flush = 1'b1;
                end else if (!in_range) begin
                    oor_d   = 1'b1;
                    state_d = HALT;
                end else if (!bus.stall && (!q_full || pop)) begin
                    push = 1'b1;
`ifdef FETCH_HALT_ON_BREAK_EN
                    if (is_break(bus.im_instruction)) begin
                        state_d = HALT;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
`else
                    pc_d = pc_q + 32'd4;
`endif
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .count     (q_count),
        .head      (head)
    );

    // Head fields read as zero while the queue is empty so decode never sees stale entries.
    assign bus.im_address     = pc_q;
    assign bus.fetch_valid    = !q_empty;
    assign bus.fetch_instr    = q_empty ? 32'h0 : head.instr;
    assign bus.fetch_pc       = q_empty ? 32'h0 : head.pc;
    assign bus.fetch_pc_plus4 = bus.fetch_pc + 32'd4;
    assign bus.out_of_range   = oor_q;
    assign bus.halted         = (state_q == HALT);

endmodule
